// File: rtl/prog_loader.sv
// -----------------------------------------------------------------------------
// prog_loader
//   Serial program loader. Consumes a little-endian byte stream of the form
//     N[31:0] | word 0 | word 1 | ... | word N-1 [| checksum byte]
//   and presents each assembled word on addr/instr with a one-cycle wr_stb,
//   holding the core in program mode (prog) while the image is written.
//
//   Optional feature: define PROG_LOADER_CHECKSUM_EN to add a trailing
//   checksum byte (running XOR of every length and data byte). Without it
//   the loader goes straight to DONE after the last word.
//
// Ports
//   clk      in   single clock, rising edge
//   rst      in   synchronous active-high reset
//   rx_data  in   [7:0] byte from the serial receiver
//   rx_valid in   rx_data valid
//   rx_ready out  loader accepts a byte this cycle
//   rearm    in   pulse: DONE/ERR -> IDLE
//   prog     out  core program-mode level
//   addr     out  [31:0] instruction-memory byte address
//   instr    out  [31:0] instruction word
//   wr_stb   out  one-cycle pulse when addr/instr carry a new word
//   done     out  sticky load-complete flag
//   err      out  sticky load-error flag
// -----------------------------------------------------------------------------
module prog_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    input  logic        rearm,
    output logic        prog,
    output logic [31:0] addr,
    output logic [31:0] instr,
    output logic        wr_stb,
    output logic        done,
    output logic        err
);

    // Counter must hold MAX_WORDS itself (word count compared after increment).
    localparam int unsigned CW = (MAX_WORDS < 2) ? 1 : $clog2(MAX_WORDS + 1);

`ifdef PROG_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_IDLE, S_LEN, S_DATA, S_FLUSH, S_CSUM, S_DONE, S_ERR
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_LEN, S_DATA, S_FLUSH, S_DONE, S_ERR
    } state_t;
`endif

    state_t          state_q;
    logic [31:0]     sh_q;          // byte assembly shift register
    logic [1:0]      byte_cnt_q;    // bytes of current length/word taken
    logic [CW-1:0]   word_cnt_q;    // words presented so far
    logic [CW-1:0]   n_q;           // word count of this image
    logic [31:0]     addr_q;
    logic [31:0]     instr_q;
    logic            wr_stb_q;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0]      csum_q;
    logic [7:0]      csum_d;
    assign csum_d = csum_q ^ rx_data;
`endif

    logic            accept;
    logic            last_byte;
    logic [31:0]     word_d;        // full word if this byte is the 4th
    logic [CW-1:0]   word_cnt_d;

    assign accept     = rx_valid & rx_ready;
    assign last_byte  = (byte_cnt_q == 2'd3);
    // Little endian: first byte ends up in [7:0] after four shifts.
    assign word_d     = {rx_data, sh_q[31:8]};
    assign word_cnt_d = word_cnt_q + 1'b1;

    // Mode outputs decode directly from the state register.
`ifdef PROG_LOADER_CHECKSUM_EN
    assign rx_ready = (state_q == S_IDLE) || (state_q == S_LEN) ||
                      (state_q == S_DATA) || (state_q == S_CSUM);
    assign prog     = (state_q == S_DATA) || (state_q == S_FLUSH) ||
                      (state_q == S_CSUM);
`else
    assign rx_ready = (state_q == S_IDLE) || (state_q == S_LEN) ||
                      (state_q == S_DATA);
    assign prog     = (state_q == S_DATA) || (state_q == S_FLUSH);
`endif
    assign done   = (state_q == S_DONE);
    assign err    = (state_q == S_ERR);
    assign addr   = addr_q;
    assign instr  = instr_q;
    assign wr_stb = wr_stb_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            sh_q       <= '0;
            byte_cnt_q <= '0;
            word_cnt_q <= '0;
            n_q        <= '0;
            addr_q     <= BASE_ADDR;
            instr_q    <= '0;
            wr_stb_q   <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            wr_stb_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        sh_q       <= word_d;
                        byte_cnt_q <= 2'd1;
                        word_cnt_q <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
                        csum_q     <= rx_data;
`endif
                        state_q    <= S_LEN;
                    end
                end
                S_LEN: begin
                    if (accept) begin
                        sh_q       <= word_d;
                        byte_cnt_q <= byte_cnt_q + 2'd1;
`ifdef PROG_LOADER_CHECKSUM_EN
                        csum_q     <= csum_d;
`endif
                        if (last_byte) begin
                            // Full 32-bit compare so oversize counts never alias.
                            if (word_d == 32'd0) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                                state_q <= S_CSUM;
`else
                                state_q <= S_DONE;
`endif
                            end else if (word_d > MAX_WORDS) begin
                                state_q <= S_ERR;
                            end else begin
                                n_q     <= CW'(word_d);
                                state_q <= S_DATA;
                            end
                        end
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        sh_q       <= word_d;
                        byte_cnt_q <= byte_cnt_q + 2'd1;
`ifdef PROG_LOADER_CHECKSUM_EN
                        csum_q     <= csum_d;
`endif
                        if (last_byte) begin
                            instr_q    <= word_d;
                            addr_q     <= BASE_ADDR + (32'(word_cnt_q) << 2);
                            wr_stb_q   <= 1'b1;
                            word_cnt_q <= word_cnt_d;
                            // Last word is presented during FLUSH, prog still high.
                            if (word_cnt_d == n_q)
                                state_q <= S_FLUSH;
                        end
                    end
                end
                S_FLUSH: begin
`ifdef PROG_LOADER_CHECKSUM_EN
                    state_q <= S_CSUM;
`else
                    state_q <= S_DONE;
`endif
                end
`ifdef PROG_LOADER_CHECKSUM_EN
                S_CSUM: begin
                    if (accept)
                        state_q <= (rx_data == csum_q) ? S_DONE : S_ERR;
                end
`endif
                S_DONE, S_ERR: begin
                    if (rearm) begin
                        byte_cnt_q <= '0;
                        state_q    <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic        rearm = 1'b0;
    logic        prog;
    logic [31:0] addr;
    logic [31:0] instr;
    logic        wr_stb;
    logic        done;
    logic        err;

    prog_loader #(.BASE_ADDR(32'h0000_0000), .MAX_WORDS(1024)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .rearm(rearm), .prog(prog), .addr(addr),
        .instr(instr), .wr_stb(wr_stb), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    wr_t exp_q[$];
    int  total = 0;
    int  bad = 0;
    int  stb_cnt = 0;
    int  flush_cnt = 0;
    bit  prog_seen = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    task automatic push_wr(input logic [31:0] a, input logic [31:0] d);
        wr_t w;
        w.a = a;
        w.d = d;
        exp_q.push_back(w);
    endtask

    // Scoreboard monitor: every write strobe pops one expected write.
    always @(negedge clk) begin
        if (!rst) begin
            if (prog) prog_seen = 1'b1;
            if (prog && !rx_ready) flush_cnt++;
            if (wr_stb) begin
                wr_t w;
                stb_cnt++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_wr_stb", addr, 32'hFFFF_FFFF);
                end else begin
                    w = exp_q.pop_front();
                    chk("wr_addr", addr, w.a);
                    chk("wr_instr", instr, w.d);
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int t;
        t = 0;
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!rx_ready) chk("rx_ready_timeout", {31'd0, rx_ready}, 32'd1);
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    endtask

    task automatic wait_flag(input string name, input bit want_err);
        for (int i = 0; i < 20; i++) begin
            if (want_err ? err : done) break;
            @(posedge clk);
            #1;
        end
        chk(name, {31'd0, (want_err ? err : done)}, 32'd1);
    endtask

    task automatic do_rearm();
        @(negedge clk);
        rearm = 1'b1;
        @(posedge clk);
        #1;
        rearm = 1'b0;
        chk("rearm_done_clr", {31'd0, done}, 32'd0);
        chk("rearm_err_clr", {31'd0, err}, 32'd0);
        chk("rearm_rx_ready", {31'd0, rx_ready}, 32'd1);
    endtask

    task automatic clr_counts();
        stb_cnt   = 0;
        flush_cnt = 0;
        prog_seen = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_rx_ready", {31'd0, rx_ready}, 32'd1);
        chk("rst_prog", {31'd0, prog}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_addr", addr, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_wr_stb", {31'd0, wr_stb}, 32'd0);

        // Two-word load
        clr_counts();
        push_wr(32'h0, 32'h0000_0013);
        push_wr(32'h4, 32'h0010_0093);
        send_word(32'd2);
        send_word(32'h0000_0013);
        send_word(32'h0010_0093);
`ifdef PROG_LOADER_CHECKSUM_EN
        send_byte(8'h92);
`endif
        wait_flag("two_word_done", 1'b0);
        chk("two_word_prog", {31'd0, prog}, 32'd0);
        chk("two_word_rx_ready", {31'd0, rx_ready}, 32'd0);
        chk("two_word_flush_cycles", flush_cnt, 1);
        chk("two_word_stb_cnt", stb_cnt, 2);
        repeat (3) @(posedge clk);
        #1;
        chk("done_sticky", {31'd0, done}, 32'd1);
        do_rearm();

        // Zero length
        clr_counts();
        send_word(32'd0);
`ifdef PROG_LOADER_CHECKSUM_EN
        send_byte(8'h00);
`else
        chk("zero_len_done_now", {31'd0, done}, 32'd1);
        chk("zero_len_prog_seen", {31'd0, prog_seen}, 32'd0);
`endif
        wait_flag("zero_len_done", 1'b0);
        chk("zero_len_stb_cnt", stb_cnt, 0);
        do_rearm();

        // Valid toggling every cycle, one word
        clr_counts();
        push_wr(32'h0, 32'hDDCC_BBAA);
        send_word(32'd1);
        @(posedge clk);
        send_byte(8'hAA); @(posedge clk); #1;
        send_byte(8'hBB); @(posedge clk); #1;
        send_byte(8'hCC); @(posedge clk); #1;
        chk("toggle_instr_held", instr, 32'h0010_0093);
        chk("toggle_addr_held", addr, 32'h4);
        send_byte(8'hDD);
`ifdef PROG_LOADER_CHECKSUM_EN
        send_byte(8'h01);
`endif
        wait_flag("toggle_done", 1'b0);
        chk("toggle_stb_cnt", stb_cnt, 1);
        do_rearm();

        // Oversize length 0x401
        clr_counts();
        send_word(32'h0000_0401);
        wait_flag("oversize_err", 1'b1);
        chk("oversize_rx_ready", {31'd0, rx_ready}, 32'd0);
        chk("oversize_prog", {31'd0, prog}, 32'd0);
        chk("oversize_done", {31'd0, done}, 32'd0);
        chk("oversize_stb_cnt", stb_cnt, 0);
        do_rearm();

        // Reset mid-load, then fresh stream
        clr_counts();
        send_word(32'd1);
        send_byte(8'h11);
        send_byte(8'h22);
        @(negedge clk);
        rst   = 1'b1;
        rearm = 1'b1;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        rearm = 1'b0;
        chk("midrst_prog", {31'd0, prog}, 32'd0);
        chk("midrst_addr", addr, 32'h0);
        chk("midrst_instr", instr, 32'h0);
        chk("midrst_rx_ready", {31'd0, rx_ready}, 32'd1);
        push_wr(32'h0, 32'h1122_3344);
        send_word(32'd1);
        send_word(32'h1122_3344);
`ifdef PROG_LOADER_CHECKSUM_EN
        send_byte(8'h45);
`endif
        wait_flag("midrst_done", 1'b0);
        chk("midrst_stb_cnt", stb_cnt, 1);

`ifdef PROG_LOADER_CHECKSUM_EN
        // Checksum match / mismatch
        do_rearm();
        push_wr(32'h0, 32'h0000_0013);
        send_word(32'd1);
        send_word(32'h0000_0013);
        send_byte(8'h12);
        wait_flag("csum_good_done", 1'b0);
        chk("csum_good_err", {31'd0, err}, 32'd0);
        do_rearm();
        push_wr(32'h0, 32'h0000_0013);
        send_word(32'd1);
        send_word(32'h0000_0013);
        send_byte(8'h13);
        wait_flag("csum_bad_err", 1'b1);
        chk("csum_bad_done", {31'd0, done}, 32'd0);
        do_rearm();
`endif

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
